fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0040_0000, first fetch address after reset.
REQ-002 Parameter: DATA_WIDTH, 32, instruction/address width; only 32 supported.
REQ-003 Port: clk  in  1  rising-edge clock.
REQ-004 Port: reset  in  1  asynchronous, active-low reset.
REQ-005 Port: imem_req  out  1  fetch request to instruction memory.
REQ-006 Port: imem_addr  out  32  word-aligned fetch address, stable while imem_req=1 and imem_ack=0.
REQ-007 Port: imem_ack  in  1  imem_rdata valid this cycle; ends current request.
REQ-008 Port: imem_rdata  in  32  fetched instruction.
REQ-009 Port: redirect_valid  in  1  branch/jump taken; restart fetch.
REQ-010 Port: redirect_pc  in  32  redirect target; bits [1:0] ignored and forced to 0.
REQ-011 Port: stall  in  1  decode cannot accept; hold head instruction.
REQ-012 Port: if_valid  out  1  if_instr/if_pc_plus4 valid.
REQ-013 Port: if_instr  out  32  head instruction to decode.
REQ-014 Port: if_pc_plus4  out  32  address of if_instr plus 4.
REQ-015 Port: if_opcode  out  6  if_instr[31:26], drives control unit OP.

Function
REQ-016 The block SHALL hold a FIFO buffer of {instr, pc_plus4} of depth DEPTH; outputs SHALL show the head entry, if_valid=1 iff count>0.
REQ-017 Pop SHALL occur when if_valid=1 and stall=0 and redirect_valid=0; push SHALL occur on imem_ack=1 in FETCH with redirect_valid=0.
REQ-018 count_next = count + push - pop; simultaneous push and pop SHALL keep count and advance head.
REQ-019 FSM states: START, FETCH, HOLD, DISCARD; imem_req SHALL be 1 in FETCH and DISCARD only.
REQ-020 START: SHALL go to FETCH after one cycle, imem_addr=RESET_PC.
REQ-021 FETCH, ack, no redirect: SHALL push, fetch address += 4, stay FETCH if count_next<DEPTH else go HOLD.
REQ-022 FETCH, no ack: SHALL stay FETCH with imem_addr unchanged.
REQ-023 HOLD: SHALL go to FETCH in the cycle after a pop.
REQ-024 Redirect in FETCH with ack, or in HOLD: SHALL flush buffer, drop rdata, set fetch address to redirect_pc, enter FETCH next cycle.
REQ-025 Redirect in FETCH without ack: SHALL flush buffer, latch target, enter DISCARD; imem_addr SHALL stay at old address.
REQ-026 DISCARD: SHALL keep imem_req=1 until imem_ack, drop that rdata, then enter FETCH at latched target; a further redirect SHALL overwrite the target.
REQ-027 Redirect SHALL take priority over push, pop and stall; if_valid SHALL be 0 the cycle after redirect.
REQ-028 While stall=1 and no redirect, if_instr and if_pc_plus4 SHALL be unchanged.
REQ-029 Address increment SHALL wrap modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
REQ-030 Latency: instruction acked at edge N SHALL appear on if_instr after edge N when buffer was empty.

Reset
REQ-031 reset=0 SHALL asynchronously force: state START, count 0, if_valid 0, imem_req 0, imem_addr RESET_PC, if_instr 0, if_pc_plus4 0.
REQ-032 Reset asserted mid-request SHALL abandon the request; no data from before reset SHALL be pushed.

Configuration
REQ-033 Macro PREFETCH_BUFFER_EN defined: DEPTH=2; zero-wait memory, no stall gives one instruction per cycle.
REQ-034 Macro undefined: DEPTH=1; zero-wait memory gives one instruction every two cycles; all other behaviour identical.

Verification
REQ-035 Reset release, ack always 1: imem_addr 0x00400000, 0x00400004, ...; if_pc_plus4 0x00400004, 0x00400008; with macro if_valid=1 every cycle.
REQ-036 Stall held 3 cycles with buffer full: imem_req=0 (HOLD), if_instr constant; release -> next instruction in order, none lost or duplicated.
REQ-037 Redirect to 0x00400100 while ack=0 with 2 wait states: old address held until ack, rdata dropped, next imem_addr 0x00400100, if_valid=0 until new ack.
REQ-038 Redirect to 0x00400203 in HOLD: buffer flushed, next imem_addr 0x00400200.
REQ-039 Fetch at 0xFFFFFFFC acked: next imem_addr 0x00000000, if_pc_plus4 0x00000000.
REQ-040 reset pulsed low mid-request with ack pending: outputs at reset values immediately; after release fetch restarts at 0x00400000.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: request/ack front end to instruction memory feeding a small {instr, pc+4} buffer.
// Define PREFETCH_BUFFER_EN for a 2-entry buffer (one fetch per cycle); otherwise the buffer holds one entry.
module fetch_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0040_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    input  logic                  stall,
    output logic                  if_valid,
    output logic [DATA_WIDTH-1:0] if_instr,
    output logic [DATA_WIDTH-1:0] if_pc_plus4,
    output logic [5:0]            if_opcode
);

`ifdef PREFETCH_BUFFER_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0]      LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(DEPTH);
    localparam logic [DATA_WIDTH-1:0] WORD     = DATA_WIDTH'(4);

    typedef enum logic [1:0] {
        START,
        FETCH,
        HOLD,
        DISCARD
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
    logic [DATA_WIDTH-1:0] target_q, target_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [DATA_WIDTH-1:0] instr_mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] pc4_mem_q   [DEPTH];

    logic                  push;
    logic                  pop;
    logic                  flush;
    logic [CNT_W-1:0]      fill_after_push;
    logic [DATA_WIDTH-1:0] redirect_target;
    logic                  redirect_pc_unused;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign redirect_target    = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
    assign redirect_pc_unused = ^redirect_pc[1:0];

    assign if_valid    = (count_q != '0);
    assign if_instr    = instr_mem_q[head_q];
    assign if_pc_plus4 = pc4_mem_q[head_q];
    assign if_opcode   = if_instr[DATA_WIDTH-1 -: 6];
    assign imem_req    = (state_q == FETCH) || (state_q == DISCARD);
    assign imem_addr   = fetch_addr_q;

    // Redirect outranks decode: a taken branch kills the head even if decode wants it.
    assign pop             = if_valid && !stall && !redirect_valid;
    assign fill_after_push = pop ? count_q : count_q + CNT_W'(1);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        target_d     = target_q;
        push         = 1'b0;
        flush        = 1'b0;
        case (state_q)
            START: begin
                state_d = FETCH;
                if (redirect_valid) begin
                    flush        = 1'b1;
                    fetch_addr_d = redirect_target;
                end
            end
            FETCH: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    if (imem_ack) begin
                        fetch_addr_d = redirect_target;
                    end else begin
                        // The bus still owns the old request; it must complete before refetching.
                        target_d = redirect_target;
                        state_d  = DISCARD;
                    end
                end else if (imem_ack) begin
                    push         = 1'b1;
                    fetch_addr_d = fetch_addr_q + WORD;
                    if (fill_after_push >= FULL_CNT) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    flush        = 1'b1;
                    fetch_addr_d = redirect_target;
                    state_d      = FETCH;
                end else if (pop) begin
                    state_d = FETCH;
                end
            end
            DISCARD: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    if (imem_ack) begin
                        fetch_addr_d = redirect_target;
                        state_d      = FETCH;
                    end else begin
                        target_d = redirect_target;
                    end
                end else if (imem_ack) begin
                    fetch_addr_d = target_q;
                    state_d      = FETCH;
                end
            end
            default: state_d = START;
        endcase
    end

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            if (push) tail_d = ptr_inc(tail_q);
            if (pop)  head_d = ptr_inc(head_q);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= START;
            fetch_addr_q <= RESET_PC;
            target_q     <= RESET_PC;
            count_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            target_q     <= target_d;
            count_q      <= count_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
        end
    end

    // NOTE: the buffer storage is reset because the head entry drives if_instr/if_pc_plus4 directly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_q[i] <= '0;
                pc4_mem_q[i]   <= '0;
            end
        end else if (push) begin
            instr_mem_q[tail_q] <= imem_rdata;
            pc4_mem_q[tail_q]   <= fetch_addr_q + WORD;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming vector table plus stall, redirect, wrap and reset sequences.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc_plus4;
    logic [5:0]  if_opcode;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic [5:0]  e_op;
    } vec_t;

    vec_t vecs [8];
    int   n_vec;

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc_plus4    (if_pc_plus4),
        .if_opcode      (if_opcode)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check(name, 32'(act), 32'(exp));
    endtask

    task automatic drive(input logic ack, input logic stl, input logic rv, input logic [31:0] rpc);
        imem_ack       = ack;
        stall          = stl;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_rdata     = mem_word(imem_addr);
    endtask

    task automatic set_vec(input int idx, input logic ack, input logic [31:0] rdata,
                           input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                           input logic [31:0] e_instr, input logic [31:0] e_pc4, input logic [5:0] e_op);
        vecs[idx].ack     = ack;
        vecs[idx].rdata   = rdata;
        vecs[idx].e_req   = e_req;
        vecs[idx].e_addr  = e_addr;
        vecs[idx].e_valid = e_valid;
        vecs[idx].e_instr = e_instr;
        vecs[idx].e_pc4   = e_pc4;
        vecs[idx].e_op    = e_op;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (2) @(negedge clk);
        check_bit("rst_req", imem_req, 1'b0);
        check("rst_addr", imem_addr, 32'h0040_0000);
        check_bit("rst_valid", if_valid, 1'b0);
        check("rst_instr", if_instr, 32'h0);
        check("rst_pc4", if_pc_plus4, 32'h0);
        reset = 1'b1;
    endtask

    // Keep acking with decode stalled until the buffer is full and fetch has parked.
    task automatic fill_until_hold(input string name);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 1'b0, 32'h0);
            if (if_valid && !imem_req) begin
                found = 1'b1;
                break;
            end
        end
        check_bit(name, found, 1'b1);
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] tmp;
        int          got;

`ifdef PREFETCH_BUFFER_EN
        n_vec = 6;
        set_vec(0, 1'b0, 32'h0,         1'b0, 32'h0040_0000, 1'b0, 32'h0,         32'h0,         6'h00);
        set_vec(1, 1'b1, 32'h2001_0001, 1'b1, 32'h0040_0000, 1'b0, 32'h0,         32'h0,         6'h00);
        set_vec(2, 1'b1, 32'h8C02_0004, 1'b1, 32'h0040_0004, 1'b1, 32'h2001_0001, 32'h0040_0004, 6'h08);
        set_vec(3, 1'b1, 32'hAC03_0008, 1'b1, 32'h0040_0008, 1'b1, 32'h8C02_0004, 32'h0040_0008, 6'h23);
        set_vec(4, 1'b1, 32'h0000_0020, 1'b1, 32'h0040_000C, 1'b1, 32'hAC03_0008, 32'h0040_000C, 6'h2B);
        set_vec(5, 1'b1, 32'h0000_0020, 1'b1, 32'h0040_0010, 1'b1, 32'h0000_0020, 32'h0040_0010, 6'h00);
`else
        n_vec = 8;
        set_vec(0, 1'b0, 32'h0,         1'b0, 32'h0040_0000, 1'b0, 32'h0,         32'h0,         6'h00);
        set_vec(1, 1'b1, 32'h2001_0001, 1'b1, 32'h0040_0000, 1'b0, 32'h0,         32'h0,         6'h00);
        set_vec(2, 1'b1, 32'h2001_0001, 1'b0, 32'h0040_0004, 1'b1, 32'h2001_0001, 32'h0040_0004, 6'h08);
        set_vec(3, 1'b1, 32'h8C02_0004, 1'b1, 32'h0040_0004, 1'b0, 32'h0,         32'h0,         6'h00);
        set_vec(4, 1'b1, 32'h8C02_0004, 1'b0, 32'h0040_0008, 1'b1, 32'h8C02_0004, 32'h0040_0008, 6'h23);
        set_vec(5, 1'b1, 32'hAC03_0008, 1'b1, 32'h0040_0008, 1'b0, 32'h0,         32'h0,         6'h00);
        set_vec(6, 1'b1, 32'hAC03_0008, 1'b0, 32'h0040_000C, 1'b1, 32'hAC03_0008, 32'h0040_000C, 6'h2B);
        set_vec(7, 1'b1, 32'h0000_0020, 1'b1, 32'h0040_000C, 1'b0, 32'h0,         32'h0,         6'h00);
`endif

        // Streaming from reset with a zero-wait memory.
        apply_reset();
        for (int i = 0; i < n_vec; i++) begin
            imem_ack       = vecs[i].ack;
            imem_rdata     = vecs[i].rdata;
            stall          = 1'b0;
            redirect_valid = 1'b0;
            check_bit($sformatf("v%0d_req", i), imem_req, vecs[i].e_req);
            check($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
            check_bit($sformatf("v%0d_valid", i), if_valid, vecs[i].e_valid);
            if (vecs[i].e_valid) begin
                check($sformatf("v%0d_instr", i), if_instr, vecs[i].e_instr);
                check($sformatf("v%0d_pc4", i), if_pc_plus4, vecs[i].e_pc4);
                check($sformatf("v%0d_op", i), 32'(if_opcode), 32'(vecs[i].e_op));
            end
            @(negedge clk);
        end

        // Stall with a full buffer, then drain in order.
        apply_reset();
        fill_until_hold("stall_fill");
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0);
            check_bit("stall_req", imem_req, 1'b0);
            check_bit("stall_valid", if_valid, 1'b1);
            check("stall_instr", if_instr, mem_word(32'h0040_0000));
            check("stall_pc4", if_pc_plus4, 32'h0040_0004);
            @(negedge clk);
        end
        exp_pc = 32'h0040_0000;
        got    = 0;
        for (int i = 0; i < 20 && got < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0);
            if (if_valid) begin
                check("drain_instr", if_instr, mem_word(exp_pc));
                check("drain_pc4", if_pc_plus4, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                got++;
            end
            @(negedge clk);
        end
        check("drain_count", 32'(got), 32'd5);

        // Redirect while parked in HOLD: unaligned target is forced to a word address.
        fill_until_hold("hold_fill");
        drive(1'b1, 1'b0, 1'b1, 32'h0040_0203);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        check_bit("hold_redir_valid", if_valid, 1'b0);
        check_bit("hold_redir_req", imem_req, 1'b1);
        check("hold_redir_addr", imem_addr, 32'h0040_0200);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        check_bit("hold_new_valid", if_valid, 1'b1);
        check("hold_new_pc4", if_pc_plus4, 32'h0040_0204);
        check("hold_new_instr", if_instr, mem_word(32'h0040_0200));

        // Redirect with the request outstanding and two wait states.
        apply_reset();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 32'h0040_0100);
        check_bit("disc_req0", imem_req, 1'b1);
        check("disc_addr0", imem_addr, 32'h0040_0000);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0);
            check_bit("disc_wait_req", imem_req, 1'b1);
            check("disc_wait_addr", imem_addr, 32'h0040_0000);
            check_bit("disc_wait_valid", if_valid, 1'b0);
            @(negedge clk);
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        imem_rdata = 32'hDEAD_BEEF;
        check("disc_ack_addr", imem_addr, 32'h0040_0000);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        check("disc_target_addr", imem_addr, 32'h0040_0100);
        check_bit("disc_dropped_valid", if_valid, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        check_bit("disc_pre_ack_valid", if_valid, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        check_bit("disc_new_valid", if_valid, 1'b1);
        check("disc_new_pc4", if_pc_plus4, 32'h0040_0104);
        check("disc_new_instr", if_instr, mem_word(32'h0040_0100));

        // A second redirect during DISCARD replaces the pending target.
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 32'h0050_0000);
        check("over_addr0", imem_addr, 32'h0040_0104);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 32'h0060_0006);
        check_bit("over_req", imem_req, 1'b1);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        check("over_hold_addr", imem_addr, 32'h0040_0104);
        @(negedge clk);
        check("over_final_addr", imem_addr, 32'h0060_0004);
        check_bit("over_final_valid", if_valid, 1'b0);

        // Address wrap at the top of the 32-bit space.
        drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        @(negedge clk);
        check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        tmp = mem_word(32'hFFFF_FFFC);
        check("wrap_next_addr", imem_addr, 32'h0);
        check_bit("wrap_valid", if_valid, 1'b1);
        check("wrap_pc4", if_pc_plus4, 32'h0);
        check("wrap_instr", if_instr, tmp);
        check("wrap_op", 32'(if_opcode), 32'(tmp[31:26]));

        // Asynchronous reset in the middle of an acked request.
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        check_bit("mid_req_before", imem_req, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check_bit("async_req", imem_req, 1'b0);
        check("async_addr", imem_addr, 32'h0040_0000);
        check_bit("async_valid", if_valid, 1'b0);
        check("async_instr", if_instr, 32'h0);
        check("async_pc4", if_pc_plus4, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        check_bit("restart_start_req", imem_req, 1'b0);
        check_bit("restart_start_valid", if_valid, 1'b0);
        @(negedge clk);
        check_bit("restart_req", imem_req, 1'b1);
        check("restart_addr", imem_addr, 32'h0040_0000);
        check_bit("restart_valid", if_valid, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        check_bit("restart_new_valid", if_valid, 1'b1);
        check("restart_new_pc4", if_pc_plus4, 32'h0040_0004);
        check("restart_new_instr", if_instr, mem_word(32'h0040_0000));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
